// File: rtl/gate_unit_arbiter_pkg.sv
// Shared constants for the gate unit arbiter and its logic unit.
// Holds the opcode encodings and the arbiter FSM state encodings.
package gate_unit_arbiter_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

endpackage

// File: rtl/gate_alu.sv
// Purely combinational 2-input bitwise logic unit (AND/OR/XOR/NAND).
// It is shared by the arbiter, and other blocks can reuse it as is.
module gate_alu
    import gate_unit_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    always_comb begin
        // NOTE: default first so every path assigns y and no latch is inferred.
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter in front of a shared gate_alu: it latches the winner's
// operands, computes in EXEC, and returns the result with a one-cycle done in RESP.
module gate_unit_arbiter
    import gate_unit_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   op,
    input  logic [W*N_REQ-1:0]   a,
    input  logic [W*N_REQ-1:0]   b,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         result,
    output logic [IDW-1:0]       done_id
);

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] pick_idx;
    logic           pick_valid;

    logic [1:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   alu_y;

    logic [1:0]     op_arr [N_REQ];
    logic [W-1:0]   a_arr  [N_REQ];
    logic [W-1:0]   b_arr  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign op_arr[i] = op[2*i +: 2];
        assign a_arr[i]  = a[W*i +: W];
        assign b_arr[i]  = b[W*i +: W];
    end

    // First set request at or above the rr pointer, wrapping past N_REQ-1 to 0.
    always_comb begin
        int cand;
        cand       = 0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = int'(rr_ptr) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!pick_valid && req[IDW'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDW'(cand);
            end
        end
    end

    gate_alu #(
        .W (W)
    ) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            win_id  <= '0;
            grant   <= '0;
            done    <= 1'b0;
            result  <= '0;
            done_id <= '0;
            // NOTE: operand latches are cleared too, so an aborted transaction
            // leaves nothing behind that could leak into a later result.
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        op_q   <= op_arr[pick_idx];
                        a_q    <= a_arr[pick_idx];
                        b_q    <= b_arr[pick_idx];
                        win_id <= pick_idx;
                        grant  <= N_REQ'(1) << pick_idx;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result  <= alu_y;
                    done    <= 1'b1;
                    done_id <= win_id;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    done   <= 1'b0;
                    grant  <= '0;
                    rr_ptr <= (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_EXEC) || (state == S_RESP);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench: a cycle-timed transaction model checked against the DUT
// every cycle, plus directed vectors with hand-computed expected values.
module tb_gate_unit_arbiter;

    localparam int N_REQ = 4;
    localparam int W     = 8;
    localparam int IDW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req;
    logic [2*N_REQ-1:0]   op;
    logic [W*N_REQ-1:0]   a;
    logic [W*N_REQ-1:0]   b;
    logic [N_REQ-1:0]     grant;
    logic                 busy;
    logic                 done;
    logic [W-1:0]         result;
    logic [IDW-1:0]       done_id;

    int n_vec  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    gate_unit_arbiter #(
        .N_REQ (N_REQ),
        .W     (W),
        .IDW   (IDW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .op      (op),
        .a       (a),
        .b       (b),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic logic [W-1:0] alu_ref(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // Transaction model: a request won at edge s holds grant after edges s and s+1,
    // shows done/result after edge s+1, and the next arbitration is at edge s+3.
    int             e        = 0;
    int             s        = 0;
    int             next_arb = 0;
    int             rr       = 0;
    int             txn_w    = 0;
    int             id_now   = 0;
    int             c        = 0;
    bit             has_txn  = 1'b0;
    logic [W-1:0]   txn_res  = '0;
    logic [W-1:0]   res_now  = '0;
    logic [N_REQ-1:0] exp_grant  = '0;
    logic           exp_done   = 1'b0;
    logic           exp_busy   = 1'b0;
    logic [W-1:0]   exp_result = '0;
    logic [IDW-1:0] exp_id     = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = 0; next_arb = 0; rr = 0; has_txn = 1'b0;
            res_now = '0; id_now = 0;
            exp_grant = '0; exp_done = 1'b0; exp_busy = 1'b0;
            exp_result = '0; exp_id = '0;
        end else begin
            e++;
            if (has_txn && e == s + 1) begin
                res_now = txn_res;
                id_now  = txn_w;
            end
            if (e >= next_arb && req != '0) begin
                for (int k = 0; k < N_REQ; k++) begin
                    c = (rr + k) % N_REQ;
                    if (req[c]) begin
                        txn_w = c;
                        break;
                    end
                end
                txn_res  = alu_ref(op[2*txn_w +: 2], a[W*txn_w +: W], b[W*txn_w +: W]);
                s        = e;
                next_arb = e + 3;
                rr       = (txn_w + 1) % N_REQ;
                has_txn  = 1'b1;
            end
            exp_busy   = has_txn && (e == s || e == s + 1);
            exp_grant  = exp_busy ? N_REQ'(1 << txn_w) : '0;
            exp_done   = has_txn && (e == s + 1);
            exp_result = res_now;
            exp_id     = IDW'(id_now);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("grant",   32'(grant),   32'(exp_grant));
            check("busy",    32'(busy),    32'(exp_busy));
            check("done",    32'(done),    32'(exp_done));
            check("result",  32'(result),  32'(exp_result));
            check("done_id", 32'(done_id), 32'(exp_id));
        end
    end

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!done && cycles < 20);
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        op[2*i +: 2] = o;
        a[W*i +: W]  = av;
        b[W*i +: W]  = bv;
        req[i]       = 1'b1;
    endtask

    task automatic serve(input int i, input logic [1:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] expv, input string name);
        int cyc;
        set_req(i, o, av, bv);
        wait_done(cyc);
        check({name, "_latency"}, 32'(cyc), 32'd2);
        check({name, "_result"},  32'(result), 32'(expv));
        check({name, "_id"},      32'(done_id), 32'(i));
        check({name, "_grant"},   32'(grant), 32'(1 << i));
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    initial begin
        int cyc;
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1;
        req = '1;
        op  = '0;
        a   = '0;
        b   = '0;
        #3 cmp_en = 1'b1;
        #9;
        check("rst_grant",   32'(grant),   32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_result",  32'(result),  32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        #8;
        @(posedge clk); #1;
        rst = 1'b0;

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (grant == '0 && cyc < 10);
        check("first_grant", 32'(grant), 32'b0001);
        wait_done(cyc);
        check("first_done_id", 32'(done_id), 32'd0);
        @(posedge clk); #1;
        req = '0;

        serve(2, 2'b01, 8'hA0, 8'h0F, 8'hAF, "single_or");
        serve(0, 2'b00, 8'hCC, 8'hAA, 8'h88, "op_and");
        serve(0, 2'b01, 8'hCC, 8'hAA, 8'hEE, "op_or");
        serve(0, 2'b10, 8'hCC, 8'hAA, 8'h66, "op_xor");
        serve(0, 2'b11, 8'hCC, 8'hAA, 8'h77, "op_nand");

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, 2'(i), 8'(8'h11 * (i + 1)), 8'h5A);
        for (int j = 0; j < 6; j++) begin
            wait_done(cyc);
            check($sformatf("fair_id%0d", j), 32'(done_id), 32'(exp_seq[j]));
        end
        @(posedge clk); #1;
        req = '0;

        set_req(1, 2'b01, 8'h12, 8'h34);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done",  32'(done),  32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        set_req(0, 2'b10, 8'hF0, 8'h3C);
        rst = 1'b0;
        wait_done(cyc);
        check("post_rst_id0",  32'(done_id), 32'd0);
        check("post_rst_res0", 32'(result),  32'hCC);
        @(posedge clk); #1;
        req[0] = 1'b0;
        wait_done(cyc);
        check("post_rst_id1",  32'(done_id), 32'd1);
        check("post_rst_res1", 32'(result),  32'h36);
        @(posedge clk); #1;
        req = '0;

        set_req(3, 2'b00, 8'hFF, 8'hFF);
        @(posedge clk); #1;
        a[W*3 +: W] = 8'h00;
        wait_done(cyc);
        check("stable_result", 32'(result),  32'hFF);
        check("stable_id",     32'(done_id), 32'd3);
        @(posedge clk); #1;
        req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_result", 32'(result), 32'hFF);
        check("idle_busy",   32'(busy),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
